// File: rtl/imem_arbiter_pkg.sv
// Shared sizes, port identifiers and ownership-state encoding for the
// instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam int WORD_LEN   = 16;
  localparam int ADDR_LEN   = 16;
  localparam int IMEM_PORTS = 2;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DBG   = 1'b1;

  typedef enum logic {
    OWN_SHARED = 1'b0,
    OWN_LOCKED = 1'b1
  } own_state_t;

endpackage

// File: rtl/imem_arbiter_rr.sv
// Two-way round-robin arbiter. The port not granted most recently wins a
// conflict; mask0 removes port 0 from contention.
module rr_arbiter2
  import imem_arbiter_pkg::*;
(
  input  logic [IMEM_PORTS-1:0] req,
  input  logic                  last,
  input  logic                  mask0,
  output logic [IMEM_PORTS-1:0] gnt
);

  logic [IMEM_PORTS-1:0] req_eff;

  always_comb begin
    req_eff = {req[PORT_DBG], req[PORT_FETCH] & ~mask0};
    gnt     = req_eff;
    if (req_eff == 2'b11) begin
      gnt = (last == PORT_DBG) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between fetch (port 0) and the
// debug loader (port 1): registered memory controls, tagged read responses.
module imem_arbiter
  import imem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IMEM_PORTS-1:0] req,
  input  logic [IMEM_PORTS-1:0] we,
  input  logic [ADDR_LEN-1:0]   addr0,
  input  logic [ADDR_LEN-1:0]   addr1,
  input  logic [WORD_LEN-1:0]   wdata0,
  input  logic [WORD_LEN-1:0]   wdata1,
  input  logic                  dbg_lock,
  output logic [IMEM_PORTS-1:0] gnt,
  output logic [IMEM_PORTS-1:0] rvalid,
  output logic [WORD_LEN-1:0]   rdata,
  output logic                  locked,
  output logic [ADDR_LEN-1:0]   mem_addr,
  output logic                  mem_we,
  output logic [WORD_LEN-1:0]   mem_wdata,
  input  logic [WORD_LEN-1:0]   mem_rdata
);

  own_state_t            state_reg, state_next;
  logic                  last_reg;
  logic                  pend_v_reg;
  logic                  pend_id_reg;
  logic [IMEM_PORTS-1:0] arb_gnt;
  logic                  accept;
  logic                  winner;
  logic [ADDR_LEN-1:0]   sel_addr;
  logic [WORD_LEN-1:0]   sel_wdata;
  logic                  sel_we;

  rr_arbiter2 u_arb (
    .req   (req),
    .last  (last_reg),
    .mask0 (state_reg == OWN_LOCKED),
    .gnt   (arb_gnt)
  );

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign gnt    = rst ? arb_gnt : '0;
  assign accept = |gnt;
  assign winner = gnt[PORT_DBG];
  assign locked = (state_reg == OWN_LOCKED);

  always_comb begin
    sel_addr  = (winner == PORT_DBG) ? addr1  : addr0;
    sel_wdata = (winner == PORT_DBG) ? wdata1 : wdata0;
    sel_we    = we[winner];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OWN_SHARED: if (dbg_lock)  state_next = OWN_LOCKED;
      OWN_LOCKED: if (!dbg_lock) state_next = OWN_SHARED;
      default:    state_next = OWN_SHARED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= OWN_SHARED;
      last_reg    <= PORT_DBG;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      pend_v_reg  <= 1'b0;
      pend_id_reg <= PORT_FETCH;
      rvalid      <= '0;
      rdata       <= '0;
    end else begin
      state_reg <= state_next;

      // The pointer only tracks shared-mode wins; locked traffic leaves it alone.
      if (accept && state_reg == OWN_SHARED) begin
        last_reg <= winner;
      end

      if (accept) begin
        mem_addr    <= sel_addr;
        mem_we      <= sel_we;
        mem_wdata   <= sel_wdata;
        pend_v_reg  <= ~sel_we;
        pend_id_reg <= winner;
      end else begin
        mem_we     <= 1'b0;
        pend_v_reg <= 1'b0;
      end

      if (pend_v_reg) begin
        rdata  <= mem_rdata;
        rvalid <= (pend_id_reg == PORT_DBG) ? 2'b10 : 2'b01;
      end else begin
        rvalid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter against a transaction-level model of
// ownership, round-robin grants and in-order memory effects.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [IMEM_PORTS-1:0] req = '0;
  logic [IMEM_PORTS-1:0] we = '0;
  logic [ADDR_LEN-1:0]   addr0 = '0, addr1 = '0;
  logic [WORD_LEN-1:0]   wdata0 = '0, wdata1 = '0;
  logic                  dbg_lock = 1'b0;
  logic [IMEM_PORTS-1:0] gnt, rvalid;
  logic [WORD_LEN-1:0]   rdata, mem_wdata, mem_rdata;
  logic [ADDR_LEN-1:0]   mem_addr;
  logic                  locked, mem_we;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .dbg_lock(dbg_lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .locked(locked), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 16'h0101) ^ 16'h5A00;
  endfunction

  // Environment memory: combinational read, write on the edge.
  logic [15:0] env_mem [0:255];
  bit          env_wr  [0:255];
  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
      env_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end
  assign mem_rdata = env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_word(int'(mem_addr[7:0]));

  // Reference model state.
  int          total = 0;
  int          bad = 0;
  logic [15:0] ref_mem [0:255];
  bit          m_locked, m_last;
  bit          p1_v, p1_id, pw_v;
  logic [15:0] p1_addr, pw_addr, pw_data;
  logic [1:0]  e_rv;
  logic [15:0] e_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_last = 1'b1;
    p1_v = 1'b0; pw_v = 1'b0; p1_id = 1'b0;
    p1_addr = '0; pw_addr = '0; pw_data = '0;
    e_rv = '0; e_rdata = '0;
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic cycle(input logic [1:0] r, input logic [1:0] w,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1, input bit lk);
    logic [1:0] eg;
    bit acc, win;
    req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; dbg_lock = lk;
    @(negedge clk);
    if (m_locked)        eg = {r[1], 1'b0};
    else if (r == 2'b11) eg = m_last ? 2'b01 : 2'b10;
    else                 eg = r;
    chk("gnt", gnt, eg);
    chk("locked", locked, m_locked);
    chk("rvalid", rvalid, e_rv);
    chk("rdata", rdata, e_rdata);
    chk("mem_we", mem_we, pw_v);
    if (pw_v || p1_v) chk("mem_addr", mem_addr, pw_v ? pw_addr : p1_addr);
    if (pw_v) chk("mem_wdata", mem_wdata, pw_data);
    $display("cyc t=%0t req=%b we=%b lk=%b gnt=%b rvalid=%b rdata=%h", $time, r, w, lk, gnt, rvalid, rdata);
    acc = |eg;
    win = eg[1];
    @(posedge clk);
    // A read sees every write accepted before it, none accepted after it.
    if (p1_v) begin
      e_rv    = p1_id ? 2'b10 : 2'b01;
      e_rdata = ref_mem[p1_addr[7:0]];
    end else begin
      e_rv = 2'b00;
    end
    if (pw_v) ref_mem[pw_addr[7:0]] = pw_data;
    p1_v    = acc && !w[win];
    pw_v    = acc && w[win];
    p1_id   = win;
    p1_addr = win ? a1 : a0;
    pw_addr = win ? a1 : a0;
    pw_data = win ? d1 : d0;
    if (acc && !m_locked) m_last = win;
    m_locked = lk;
    #1;
  endtask

  task automatic do_reset(input logic [1:0] r_hold);
    req = r_hold;
    rst = 1'b0;
    #2;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    $display("reset t=%0t gnt=%b rvalid=%b", $time, gnt, rvalid);
    req = '0; we = '0; dbg_lock = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    bit lk;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    #1;
    do_reset(2'b11);

    // Fetch streams reads of 0..9.
    for (int i = 0; i < 10; i++) cycle(2'b01, 2'b00, 16'(i), 16'h0, 16'h0, 16'h0, 1'b0);
    idle(2);

    // Both ports contend; grants alternate.
    for (int i = 0; i < 8; i++) cycle(2'b11, 2'b00, 16'd4, 16'd8, 16'h0, 16'h0, 1'b0);
    idle(2);

    // Loader write followed directly by a fetch read of the same word.
    cycle(2'b10, 2'b10, 16'h0, 16'd5, 16'h0, 16'hBEEF, 1'b0);
    cycle(2'b01, 2'b00, 16'd5, 16'h0, 16'h0, 16'h0, 1'b0);
    idle(3);

    // Lock with both ports requesting, then release.
    for (int i = 0; i < 6; i++) cycle(2'b11, 2'b00, 16'd4, 16'd8, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(2'b11, 2'b00, 16'd4, 16'd8, 16'h0, 16'h0, 1'b0);
    idle(2);

    // Reset right after an accepted read drops the response.
    cycle(2'b01, 2'b00, 16'd3, 16'h0, 16'h0, 16'h0, 1'b0);
    do_reset(2'b01);
    idle(3);

    // Lock rises in the same cycle a fetch read is accepted.
    cycle(2'b01, 2'b00, 16'd7, 16'h0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(2'b11, 2'b00, 16'd2, 16'd9, 16'h0, 16'h0, 1'b1);
    idle(2);

    // Random traffic with lock toggles and one mid-run reset.
    lk = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) lk = ~lk;
      if (i == 300) do_reset(2'($urandom_range(0, 3)));
      if (i == 300) lk = 1'b0;
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)),
            16'($urandom), 16'($urandom), lk);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter and access sequencer for the single-port instruction memory `mem_instr`. It shares the memory between the fetch unit (port 0) and the debug/program-loader port (port 1), registers the memory address and write controls, and returns registered read data tagged to the requester. It sits between the core's fetch stage and the loader on one side and `mem_instr` on the other. A lock lets the loader take exclusive ownership while it rewrites the program.

## Interface
- `WORD_LEN` (define, 16): data word width.
- `ADDR_LEN` (define, 16): address width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `req` input 2: per-port access request; bit i belongs to port i.
- `we` input 2: per-port write enable, qualified by `req`.
- `addr0`, `addr1` input `ADDR_LEN`: per-port address.
- `wdata0`, `wdata1` input `WORD_LEN`: per-port write data.
- `dbg_lock` input 1: port 1 requests exclusive ownership.
- `gnt` output 2: combinational one-hot grant; `req[i] & gnt[i]` means the request is accepted this cycle.
- `rvalid` output 2: registered one-cycle read-response strobe per port.
- `rdata` output `WORD_LEN`: registered read data, valid when either `rvalid` bit is set.
- `locked` output 1: registered flag; port 1 owns the memory.
- `mem_addr` output `ADDR_LEN`: registered address to `mem_instr`.
- `mem_we` output 1: registered write strobe to memory.
- `mem_wdata` output `WORD_LEN`: registered write data.
- `mem_rdata` input `WORD_LEN`: combinational read data from memory.

## Operation
- Ownership FSM states: `SHARED` and `LOCKED`.
  - `SHARED` -> `LOCKED` when `dbg_lock` is high, sampled at the edge.
  - `LOCKED` -> `SHARED` when `dbg_lock` is low.
  - `locked` = (state == `LOCKED`).
- In `SHARED`, round-robin arbitration between requesting ports.
  - A 1-bit `last` pointer holds the most recently granted port; the other port wins on conflict.
  - With a single requester, that requester wins.
  - `last` updates only on an accepted request.
- In `LOCKED`, `gnt[0]` is forced to 0. Port 1 is granted whenever it requests. `last` is unchanged.
- `gnt` is 0 for a port that is not requesting. At most one grant bit is high.
- Accept (edge at end of cycle N):
  - `mem_addr` <= winner's address.
  - `mem_we` <= winner's `we`.
  - `mem_wdata` <= winner's data.
  - If the access is a read: `pend_v` <= 1 and `pend_id` <= winner.
- No accept at an edge: `mem_we` <= 0 and `pend_v` <= 0. `mem_addr` and `mem_wdata` hold their values.
- Read response: at the edge ending cycle N+1, if `pend_v` is set, `rdata` <= `mem_rdata` and `rvalid[pend_id]` <= 1. Otherwise `rvalid` <= 0 and `rdata` holds.
- Writes produce no response. The memory samples `mem_we` at the edge ending cycle N+1.
- Responses have no backpressure. Requesters must be able to sink one response per cycle.

## Timing
- Read latency: request accepted in cycle N, `rvalid` high in cycle N+2.
- Throughput: one access per cycle, back-to-back and mixed between ports. Responses return in accept order.
- Reset values (asserted asynchronously, any cycle):
  - State `SHARED`, `last`=1 (port 0 wins the first conflict), `locked`=0.
  - `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
  - `pend_v`=0, `rvalid`=0, `rdata`=0.
  - `gnt`=0 while reset is asserted.
- Reset mid-operation: in-flight reads are dropped with no `rvalid`, and no write is issued.
- `dbg_lock` rising while port 0 has a read in flight: that read still completes with `rvalid[0]`. Fetch grants stop in the cycle after the lock edge.
- Lock and arbitration take effect on state, not combinationally. In the cycle `dbg_lock` first rises, `SHARED` arbitration still applies.
- Read and write to the same address in consecutive accepts: the read returns memory content as of its own access cycle.

## Structure
- Add `IMEM_PORTS` (2), port IDs `PORT_FETCH` (0) and `PORT_DBG` (1), and FSM state encodings `OWN_SHARED`/`OWN_LOCKED` to the shared `defines.v`, alongside `WORD_LEN`/`ADDR_LEN`.
- One sub-module, `rr_arbiter2`: inputs `req[1:0]`, `last`, `mask0`; output one-hot `gnt`. Purely combinational.
- The pipeline registers and the FSM live in `imem_arbiter`.

## Test plan
- Reset, then only port 0 reads addr 0..9 back-to-back -> `gnt[0]` every cycle; `rvalid[0]` from cycle 2 for 10 cycles; `rdata` = memory words 0..9 in order.
- Both ports request every cycle (addr0=4, addr1=8) -> grants alternate 0,1,0,1; `rvalid` alternates; each `rdata` matches its port's address.
- Port 1 writes 0xBEEF to addr 5, then port 0 reads addr 5 one cycle later -> `rvalid[0]` with `rdata`=0xBEEF; no `rvalid` for the write.
- `dbg_lock`=1 with both ports requesting -> after the lock edge `gnt[0]`=0 and `locked`=1; port 1 is served every cycle; lock release restores alternation.
- Port 0 read accepted, `rst` pulsed low the next cycle -> no `rvalid`; all outputs are 0 while `rst` is low.
- Port 0 read accepted in the same cycle `dbg_lock` rises -> `rvalid[0]` still arrives two cycles later; no further port-0 grants.
